bus_responder: RTL
==================

Name: bus_responder

Overview:
- Slave-side counterpart of the CPU's multiplexed external bus: a memory- or IO-mapped 8085-style peripheral.
- Samples haddress/laddress_data/ALE/RDn/WRn/IOMn synchronously, latches the address while ALE is high, and decodes a hit against a base address.
- Serves reads by driving laddress_data and commits writes into an internal byte array; inserts wait states through READY.
- Used as on-board RAM/IO model in system benches and FPGA builds.

Parameters:
ADDR_W, 8, internal array depth = 2**ADDR_W bytes; legal 1..8
BASE, 16'h2000, decode base; bits [ADDR_W-1:0] must be zero
IS_IO, 0, 0 = respond when IOMn=0 (memory); 1 = respond when IOMn=1 (IO)
WAIT_STATES, 0, READY-low cycles inserted per access; legal 0..7

Ports:
clk_out  in  1  bus clock (CPU clock output); all logic on rising edge
resetn_in  in  1  synchronous active-low reset
haddress  in  8  address A15..A8
laddress_data  inout  8  multiplexed A7..A0 / D7..D0
ALE  in  1  address latch enable, active high
RDn  in  1  read strobe, active low
WRn  in  1  write strobe, active low
IOMn  in  1  IO/memory select
READY  out  1  0 = wait requested; 1 otherwise
sel  out  1  1 while this block owns the current access (WAIT or ACTIVE)

Behaviour:
- Reset (resetn_in=0 sampled at an edge): state=IDLE, READY=1, sel=0, laddress_data released to Z, wait counter=0, addr_q=0. Array contents are not reset.
- Address latch: on every edge with ALE=1, addr_q <= {haddress, laddress_data} and iom_q <= IOMn. The value from the last ALE-high edge is used.
- hit = (iom_q == IS_IO) && (addr_q[15:ADDR_W] == BASE[15:ADDR_W]); index = addr_q[ADDR_W-1:0].
- States:
  - IDLE: on a sampled edge with exactly one strobe low and ALE=0: if hit, go to WAIT when WAIT_STATES>0, otherwise ACTIVE; if not hit, go to MISS.
  - WAIT: READY=0, sel=1. Counter loads WAIT_STATES-1 on entry and decrements each edge. Go to ACTIVE on the edge where the counter is 0. READY is therefore 0 for exactly WAIT_STATES cycles.
  - ACTIVE read: laddress_data = mem[index] continuously while in state; READY=1, sel=1. The first drive cycle is 1+WAIT_STATES edges after RDn is first sampled low. RDn sampled high -> IDLE, with the bus released on the same edge.
  - ACTIVE write: wdata_q <= laddress_data on each edge with WRn=0. On the edge WRn is sampled high, mem[index] <= wdata_q (last low-phase value) -> IDLE.
  - MISS: bus never driven, READY=1; wait until both strobes are sampled high -> IDLE.
- Write data is not captured during WAIT; only ACTIVE-phase samples commit.
- Violations:
  - RDn and WRn both low in any state: no drive, no commit, go to MISS.
  - ALE sampled high in WAIT/ACTIVE: abort (no commit), release the bus, re-latch the address, go to IDLE.
- The bus is never driven outside ACTIVE read. The output enable is registered so that no drive occurs on the edge RDn rises.
- Reset mid-access: an in-flight write is discarded; bus released and READY=1 on the reset edge.
- Strobe low in IDLE with no prior ALE uses the stale addr_q; this is legal.

Decomposition:
- Shared package bus_pkg:
  - state enum {IDLE, WAIT, ACTIVE, MISS}
  - constant BUS_IDLE_Z = 8'hzz
  - function addr_hit(addr, iom, base, is_io, addr_w)
- One sub-module bus_ram: 2**ADDR_W x 8 register array with synchronous write, asynchronous read, no reset.
- Top bus_responder holds the latch, decode, FSM, wait counter and tristate.

Test Plan:
- Memory write then read, WAIT_STATES=0, BASE=16'h2000:
  - stimulus: ALE cycle with addr 2034, WRn low 2 cycles with data A5; then ALE 2034, RDn low 2 cycles.
  - response: laddress_data=A5 from the 2nd RDn-low edge, Z after RDn rises, READY always 1.
- WAIT_STATES=3, read 20FF:
  - response: READY=0 for exactly 3 cycles starting the edge after RDn is sampled low, sel=1 throughout; data driven on the 5th edge after RDn low.
- Decode miss, BASE=2000:
  - stimulus: write 3010=77, then read 3010; then IS_IO=0 access to 2010 with IOMn=1.
  - response: bus stays Z, READY=1, sel=0, mem[10] unchanged.
- Write data changing during the strobe:
  - stimulus: WRn low 3 cycles with data 11, 22, 33.
  - response: mem[index]=33 after WRn rises.
- Violations:
  - RDn and WRn both low: no drive, no write.
  - ALE pulse during ACTIVE write: no commit, new address latched.
- Reset mid-read with WAIT_STATES=2:
  - stimulus: resetn_in=0 for 1 edge during WAIT.
  - response: READY=1, sel=0, bus Z on that edge; a following normal read of a prior write returns the stored value.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types, constants and address decode helper for the bus responder.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACTIVE = 2'd2,
    MISS   = 2'd3
  } bus_state_e;

  // Value placed on the multiplexed bus whenever this block is not driving it.
  localparam logic [7:0] BUS_IDLE_Z = 8'hzz;

  // True when the latched cycle type matches and the upper address bits
  // (above the array index) equal those of the decode base.
  function automatic logic addr_hit(
    input logic [15:0] addr,
    input logic        iom,
    input logic [15:0] base,
    input logic        is_io,
    input int unsigned addr_w
  );
    logic [15:0] mask;
    mask = 16'hffff << addr_w;
    return (iom == is_io) && ((addr & mask) == (base & mask));
  endfunction

endpackage

// File: rtl/bus_ram.sv
// Byte array behind the bus responder: synchronous write, asynchronous read,
// contents deliberately left unreset.
module bus_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [2**ADDR_W];

  // Commit one byte on a write-enable edge.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/bus_responder.sv
// 8085-style multiplexed-bus slave: latches the address on ALE, decodes a hit
// against BASE, optionally inserts wait states, then serves reads onto the
// shared AD bus or commits writes into a local byte array.
module bus_responder
  import bus_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter logic [15:0] BASE        = 16'h2000,
  parameter bit          IS_IO       = 1'b0,
  parameter int          WAIT_STATES = 0
) (
  input  logic       clk_out,
  input  logic       resetn_in,
  input  logic [7:0] haddress,
  inout  wire  [7:0] laddress_data,
  input  logic       ALE,
  input  logic       RDn,
  input  logic       WRn,
  input  logic       IOMn,
  output logic       READY,
  output logic       sel
);

  localparam logic [2:0] WS_M1 = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  bus_state_e        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [15:0]       addr_q;
  logic              iom_q;
  logic              wr_q;
  logic [7:0]        wdata_q;
  logic              oe_q;

  logic              hit;
  logic [ADDR_W-1:0] idx;
  logic              both_low;
  logic              one_low;
  logic              mem_we;
  logic [7:0]        rdata;

  assign hit      = addr_hit(addr_q, iom_q, BASE, IS_IO, ADDR_W);
  assign idx      = addr_q[ADDR_W-1:0];
  assign both_low = !RDn && !WRn;
  assign one_low  = RDn ^ WRn;

  // A write lands when its strobe is seen high in ACTIVE, unless an ALE abort
  // or reset arrives on the same edge.
  assign mem_we = resetn_in && (state_q == ACTIVE) && wr_q && WRn && !ALE;

  bus_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk_out),
    .we_i    (mem_we),
    .addr_i  (idx),
    .wdata_i (wdata_q),
    .rdata_o (rdata)
  );

  // State register and wait counter.
  always_ff @(posedge clk_out) begin
    if (!resetn_in) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state decode; strobe collisions win over everything, then ALE aborts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (both_low) begin
          state_d = MISS;
        end else if (!ALE && one_low) begin
          if (!hit) begin
            state_d = MISS;
          end else if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = WS_M1;
          end else begin
            state_d = ACTIVE;
          end
        end
      end
      WAIT: begin
        if (both_low) begin
          state_d = MISS;
        end else if (ALE) begin
          state_d = IDLE;
        end else if (cnt_q == 3'd0) begin
          state_d = ACTIVE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ACTIVE: begin
        if (both_low) begin
          state_d = MISS;
        end else if (ALE) begin
          state_d = IDLE;
        end else if (wr_q ? WRn : RDn) begin
          state_d = IDLE;
        end
      end
      MISS: begin
        if (RDn && WRn) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus-facing status outputs derived from the current state.
  always_comb begin
    READY = (state_q != WAIT);
    sel   = (state_q == WAIT) || (state_q == ACTIVE);
  end

  // Address latch, access direction, write-data capture and registered drive enable.
  always_ff @(posedge clk_out) begin
    if (!resetn_in) begin
      addr_q  <= 16'h0000;
      iom_q   <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= 8'h00;
      oe_q    <= 1'b0;
    end else begin
      if (ALE) begin
        addr_q <= {haddress, laddress_data};
        iom_q  <= IOMn;
      end
      if (state_q == IDLE && one_low) begin
        wr_q <= !WRn;
      end
      if (state_q == ACTIVE && wr_q && !WRn) begin
        wdata_q <= laddress_data;
      end
      // Drive only after a full edge in ACTIVE, and drop on the edge that leaves it.
      oe_q <= (state_q == ACTIVE) && (state_d == ACTIVE) && !wr_q;
    end
  end

  assign laddress_data = oe_q ? rdata : BUS_IDLE_Z;

endmodule
